// File: rtl/alu_io_pkg.sv
// Shared types for the front-panel operand entry block: FSM states and the ALU flag layout.
package alu_io_pkg;

    localparam int unsigned FLAGS_W = 7;

    typedef enum logic [2:0] {
        StLoadA  = 3'd0,
        StLoadB  = 3'd1,
        StLoadOp = 3'd2,
        StExec   = 3'd3,
        StShow   = 3'd4
    } entry_state_e;

    // Field order matches the ALU Flags bus, MSB first.
    typedef struct packed {
        logic great;
        logic less;
        logic equal;
        logic overflow;
        logic negative;
        logic zero;
        logic carry_out;
    } alu_flags_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw button, debounces its level and emits a one-cycle pulse on each press.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q, level_prev_d;
    logic            synced;

    assign synced = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], btn_i};
        cnt_d        = '0;
        level_d      = level_q;
        level_prev_d = level_q;
        // The level follows only after DEBOUNCE_CYCLES consecutive differing samples.
        if (synced != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry controller: latches A, B and opcode from the switches on button presses,
// then captures the ALU result and flags for the LED display.
module operand_entry
    import alu_io_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned OPW             = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   Sw,
    input  logic               BtnLoad,
    input  logic               BtnClear,
    input  logic [WIDTH-1:0]   Result,
    input  logic [FLAGS_W-1:0] Flags,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [OPW-1:0]     Opcode,
    output logic [WIDTH-1:0]   ResultReg,
    output logic [FLAGS_W-1:0] FlagsReg,
    output logic               Valid,
    output logic [1:0]         Stage,
    output logic [WIDTH-1:0]   Display
);

    logic load_pulse;
    logic clear_pulse;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .btn_i  (BtnLoad),
        .press_o(load_pulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .btn_i  (BtnClear),
        .press_o(clear_pulse)
    );

    entry_state_e     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_flags_t       flags_q, flags_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = valid_q;
        // Clear has priority; a coincident load pulse is dropped.
        if (clear_pulse) begin
            state_d = StLoadA;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            flags_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StLoadA: begin
                    if (load_pulse) begin
                        a_d     = Sw;
                        state_d = StLoadB;
                    end
                end
                StLoadB: begin
                    if (load_pulse) begin
                        b_d     = Sw;
                        state_d = StLoadOp;
                    end
                end
                StLoadOp: begin
                    if (load_pulse) begin
                        op_d    = Sw[OPW-1:0];
                        state_d = StExec;
                    end
                end
                StExec: begin
                    res_d   = Result;
                    flags_d = alu_flags_t'(Flags);
                    valid_d = 1'b1;
                    state_d = StShow;
                end
                StShow: begin
                    if (load_pulse) begin
                        valid_d = 1'b0;
                        state_d = StLoadA;
                    end
                end
                default: state_d = StLoadA;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StLoadA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign Opcode    = op_q;
    assign ResultReg = res_q;
    assign FlagsReg  = flags_q;
    assign Valid     = valid_q;
    // EXEC and SHOW both report 3.
    assign Stage     = (state_q == StShow) ? 2'd3 : state_q[1:0];
    assign Display   = (state_q == StShow) ? res_q : Sw;

endmodule
